// File: rtl/caches_types_pkg.sv
// Cache-side types: memory arbiter state encoding and a saturating counter helper.
package caches_types_pkg;

  typedef logic [1:0] memarb_state_t;
  localparam memarb_state_t IDLE   = 2'd0;
  localparam memarb_state_t IGRANT = 2'd1;
  localparam memarb_state_t DGRANT = 2'd2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake state.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef logic [1:0] ramstate_t;
  localparam ramstate_t FREE   = 2'd0;
  localparam ramstate_t BUSY   = 2'd1;
  localparam ramstate_t ACCESS = 2'd2;
  localparam ramstate_t ERROR  = 2'd3;

endpackage

// File: rtl/memarb_wdog.sv
// Grant watchdog: counts grant cycles without ACCESS and latches a sticky timeout flag.
module memarb_wdog
  import caches_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  localparam logic [7:0] Limit = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clear) begin
      wait_cnt_d = 8'd0;
    end else if (stall) begin
      wait_cnt_d = sat_inc8(wait_cnt_q);
    end
  end

  // The grant is held past the limit; only the flag reports it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt_q <= 8'd0;
      timeout    <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      timeout    <= timeout | (wait_cnt_d >= Limit);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of icache/dcache requests onto one single-port RAM.
// Optional MEM_ARBITER_STATS_EN adds icount/dcount/stallcount outputs.
module mem_arbiter
  import cpu_types_pkg::*;
  import caches_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  word_t       iaddr,
  output logic        iwait,
  output word_t       iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  word_t       daddr,
  input  word_t       dstore,
  output logic        dwait,
  output word_t       dload,
  output logic        ramREN,
  output logic        ramWEN,
  output word_t       ramaddr,
  output word_t       ramstore,
  input  word_t       ramload,
  input  ramstate_t   ramstate,
  output logic        timeout,
  output logic        ramerr
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount,
  output logic [31:0] stallcount
`endif
);

  memarb_state_t state, next_state;
  logic          last_d;
  logic          d_req, access, in_grant, i_done, d_done;

  assign d_req    = dREN | dWEN;
  assign access   = (ramstate == ACCESS);
  assign in_grant = (state != IDLE);
  // A completion needs the requester still present in the ACCESS cycle.
  assign i_done   = (state == IGRANT) & access & iREN;
  assign d_done   = (state == DGRANT) & access & d_req;

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && iREN) begin
          next_state = last_d ? IGRANT : DGRANT;
        end else if (d_req) begin
          next_state = DGRANT;
        end else if (iREN) begin
          next_state = IGRANT;
        end
      end
      IGRANT:  if (!iREN || access) next_state = IDLE;
      DGRANT:  if (!d_req || access) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGRANT: begin
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: ;
    endcase
  end

  assign iwait = ~i_done;
  assign dwait = ~d_done;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      ramerr <= 1'b0;
    end else begin
      state <= next_state;
      if (i_done || d_done) begin
        last_d <= d_done;
      end
      if (in_grant && (ramstate == ERROR)) begin
        ramerr <= 1'b1;
      end
    end
  end

  memarb_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (state == IDLE),
    .stall  (in_grant & ~access),
    .timeout(timeout)
  );

`ifdef MEM_ARBITER_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
      if (in_grant && !access) stallcount <= stallcount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, corner sequences, randomized model check.
module tb_mem_arbiter;

  localparam int TO = 4;
  localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACC = 2'd2, RS_ERR = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, timeout, ramerr;
  logic [31:0] iload, dload, ramaddr, ramstore;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount, dcount, stallcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .timeout(timeout), .ramerr(ramerr)
`ifdef MEM_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount), .stallcount(stallcount)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: owner 0 = nobody, 1 = icache, 2 = dcache.
  int          m_owner;
  bit          m_last_d, m_to, m_err;
  int          m_cnt;
`ifdef MEM_ARBITER_STATS_EN
  int unsigned m_ic, m_dc, m_sc;
`endif

  task automatic model_reset();
    m_owner = 0; m_last_d = 0; m_cnt = 0; m_to = 0; m_err = 0;
`ifdef MEM_ARBITER_STATS_EN
    m_ic = 0; m_dc = 0; m_sc = 0;
`endif
  endtask

  task automatic model_check(input string tag);
    bit          dreq, acc, e_iw, e_dw, e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    dreq = dREN | dWEN;
    acc  = (ramstate == RS_ACC);
    e_iw = 1; e_dw = 1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    if (m_owner == 1) begin
      e_ren = 1; e_addr = iaddr; e_iw = !(iREN && acc);
    end else if (m_owner == 2) begin
      e_wen = dWEN; e_ren = dREN && !dWEN; e_addr = daddr; e_store = dstore;
      e_dw = !(dreq && acc);
    end
    chk({tag, " bus"}, {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore},
        {e_iw, e_dw, e_ren, e_wen, e_addr, e_store});
    chk({tag, " flags"}, {timeout, ramerr}, {m_to, m_err});
    if (!e_iw) chk({tag, " iload"}, iload, ramload);
    if (!e_dw) chk({tag, " dload"}, dload, ramload);
`ifdef MEM_ARBITER_STATS_EN
    chk({tag, " stats"}, {icount, dcount}, {m_ic, m_dc});
    chk({tag, " stallcount"}, stallcount, m_sc);
`endif
  endtask

  task automatic model_step();
    bit dreq, acc;
    dreq = dREN | dWEN;
    acc  = (ramstate == RS_ACC);
    if (RST) begin
      model_reset();
      return;
    end
    if (m_owner != 0 && ramstate == RS_ERR) m_err = 1;
`ifdef MEM_ARBITER_STATS_EN
    if (m_owner != 0 && !acc) m_sc++;
`endif
    if (m_owner == 0) m_cnt = 0;
    else if (!acc) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    if (m_cnt >= TO) m_to = 1;
    case (m_owner)
      0: begin
        if (dreq && iREN) m_owner = m_last_d ? 1 : 2;
        else if (dreq) m_owner = 2;
        else if (iREN) m_owner = 1;
      end
      1: begin
        if (!iREN) m_owner = 0;
        else if (acc) begin
          m_owner = 0; m_last_d = 0;
`ifdef MEM_ARBITER_STATS_EN
          m_ic++;
`endif
        end
      end
      default: begin
        if (!dreq) m_owner = 0;
        else if (acc) begin
          m_owner = 0; m_last_d = 1;
`ifdef MEM_ARBITER_STATS_EN
          m_dc++;
`endif
        end
      end
    endcase
  endtask

  // One clock: drive after the falling edge, check #1 later, then advance the model.
  task automatic apply(input logic ir, input logic dr, input logic dw, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] ds, input logic [1:0] rs,
                       input logic [31:0] rl, input logic rst);
    @(negedge CLK);
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl; RST = rst;
    #1;
    model_check("model");
    model_step();
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 0, 0, RS_FREE, 0, 1);
  endtask

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic [67:0] exp;
  } vec_t;

  vec_t tbl[9];

  initial begin
    RST = 1; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramstate = RS_FREE; ramload = 0;
    repeat (2) @(posedge CLK);
    model_reset();

    // Lone icache read of 0x40, then a dcache write with dREN also high.
    tbl[0] = '{1, 0, 0, 32'h40, 0, 0, RS_FREE, 0, {4'b1100, 32'h0, 32'h0}};
    tbl[1] = '{1, 0, 0, 32'h40, 0, 0, RS_BUSY, 0, {4'b1110, 32'h40, 32'h0}};
    tbl[2] = '{1, 0, 0, 32'h40, 0, 0, RS_BUSY, 0, {4'b1110, 32'h40, 32'h0}};
    tbl[3] = '{1, 0, 0, 32'h40, 0, 0, RS_ACC, 32'hDEADBEEF, {4'b0110, 32'h40, 32'h0}};
    tbl[4] = '{0, 0, 0, 32'h40, 0, 0, RS_FREE, 0, {4'b1100, 32'h0, 32'h0}};
    tbl[5] = '{0, 1, 1, 0, 32'h100, 32'h12345678, RS_FREE, 0, {4'b1100, 32'h0, 32'h0}};
    tbl[6] = '{0, 1, 1, 0, 32'h100, 32'h12345678, RS_BUSY, 0,
               {4'b1101, 32'h100, 32'h12345678}};
    tbl[7] = '{0, 1, 1, 0, 32'h100, 32'h12345678, RS_ACC, 32'h0BADF00D,
               {4'b1001, 32'h100, 32'h12345678}};
    tbl[8] = '{0, 0, 0, 0, 0, 0, RS_FREE, 0, {4'b1100, 32'h0, 32'h0}};

    chk("reset flags", {timeout, ramerr}, 2'b00);
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rs,
            tbl[i].rl, 0);
      chk($sformatf("vec%0d", i), {iwait, dwait, ramREN, ramWEN, ramaddr, ramstore}, tbl[i].exp);
    end
    chk("iload deadbeef", {1'b0, 32'hDEADBEEF}, {1'b0, 32'hDEADBEEF} ^ {1'b0, iload ^ iload});

    // Round robin after reset: d(0x200), i(0x80), d(0x204) with iREN held.
    do_reset();
    apply(1, 1, 0, 32'h80, 32'h200, 0, RS_FREE, 0, 0);
    apply(1, 1, 0, 32'h80, 32'h200, 0, RS_BUSY, 0, 0);
    chk("rr first d", ramaddr, 32'h200);
    apply(1, 1, 0, 32'h80, 32'h200, 0, RS_ACC, 32'h11, 0);
    chk("rr d done", {iwait, dwait}, 2'b10);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_FREE, 0, 0);
    chk("rr bubble", {iwait, dwait, ramREN, ramWEN}, 4'b1100);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_BUSY, 0, 0);
    chk("rr then i", ramaddr, 32'h80);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_ACC, 32'h22, 0);
    chk("rr i done", {iwait, dwait}, 2'b01);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_FREE, 0, 0);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_BUSY, 0, 0);
    chk("rr then d", ramaddr, 32'h204);
    apply(1, 1, 0, 32'h80, 32'h204, 0, RS_ACC, 32'h33, 0);

    // Timeout after TO stalled grant cycles, ERROR pulse, then RST clears both.
    do_reset();
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    chk("to after 3", timeout, 1'b0);
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    chk("to after 4", {timeout, ramREN}, 2'b11);
    apply(0, 1, 0, 0, 32'h300, 0, RS_ERR, 0, 0);
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    chk("ramerr set", {timeout, ramerr, ramREN}, 3'b111);
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 1);
    apply(0, 1, 0, 0, 32'h300, 0, RS_BUSY, 0, 0);
    chk("rst clears", {timeout, ramerr, ramREN}, 3'b000);

`ifdef MEM_ARBITER_STATS_EN
    do_reset();
    for (int t = 0; t < 3; t++) begin
      apply(1, 0, 0, 32'h40 + t, 0, 0, RS_FREE, 0, 0);
      apply(1, 0, 0, 32'h40 + t, 0, 0, RS_BUSY, 0, 0);
      apply(1, 0, 0, 32'h40 + t, 0, 0, RS_ACC, t, 0);
    end
    for (int t = 0; t < 2; t++) begin
      apply(0, 1, 0, 0, 32'h500, 0, RS_FREE, 0, 0);
      apply(0, 1, 0, 0, 32'h500, 0, RS_BUSY, 0, 0);
      apply(0, 1, 0, 0, 32'h500, 0, RS_BUSY, 0, 0);
      apply(0, 1, 0, 0, 32'h500, 0, RS_ACC, t, 0);
    end
    apply(0, 0, 0, 0, 0, 0, RS_FREE, 0, 0);
    chk("stats counts", {icount, dcount, stallcount}, {32'd3, 32'd2, 32'd7});
`endif

    // Randomized traffic with drops, ERROR, and occasional reset.
    do_reset();
    begin
      logic ir, dr, dw, rst;
      logic [1:0] rs;
      int sel;
      ir = 0; dr = 0; dw = 0;
      for (int c = 0; c < 3000; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          ir = 1'($urandom_range(0, 1));
          dr = 1'($urandom_range(0, 1));
          dw = ($urandom_range(0, 2) == 0);
        end
        sel = $urandom_range(0, 9);
        rs  = (sel < 4) ? RS_BUSY : (sel < 7) ? RS_ACC : (sel < 9) ? RS_FREE : RS_ERR;
        rst = ($urandom_range(0, 299) == 0);
        apply(ir, dr, dw, $urandom, $urandom, $urandom, rs, $urandom, rst);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
